// File: rtl/mem_ooo_responder.sv
// Out-of-order read responder behind the ROB memory port.
// Slots count down a pseudo-random latency, then retire round-robin.
module mem_ooo_responder #(
  parameter int unsigned SWIDTH    = 4,
  parameter int unsigned AWIDTH    = 10,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned LAT_MIN   = 2,
  parameter int unsigned LAT_WIDTH = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [DWIDTH-1:0] DATA_BASE = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              mem_req_val,
  input  logic [AWIDTH-1:0] mem_req_addr,
  input  logic [SWIDTH-1:0] mem_req_ID,
  input  logic              cfg_fixed_lat,
  output logic              mem_rsp_val,
  output logic [SWIDTH-1:0] mem_rsp_ID,
  output logic [DWIDTH-1:0] mem_rsp_data,
  output logic [SWIDTH:0]   outstanding,
  output logic              err_dup
);

  localparam int SLOTS = 1 << SWIDTH;
  localparam int CW    = LAT_WIDTH + 2;

  logic [SLOTS-1:0]  valid_q;
  logic [AWIDTH-1:0] addr_q [SLOTS];
  logic [CW-1:0]     cnt_q  [SLOTS];
  logic [SWIDTH-1:0] rr_q;
  logic [15:0]       lfsr_q;

  logic              win_val;
  logic [SWIDTH-1:0] win_id;
  logic [SWIDTH-1:0] idx;
  logic              acc;
  logic [CW-1:0]     lat;
  logic              fb;

  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  assign lat = CW'(LAT_MIN)
             + (cfg_fixed_lat ? '0 : CW'(lfsr_q[LAT_WIDTH-1:0]));

  // A slot retiring on this edge may be refilled on the same edge
  assign acc = mem_req_val
             && (!valid_q[mem_req_ID]
                 || (win_val && win_id == mem_req_ID));

  always_comb begin
    win_val = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int i = 0; i < SLOTS; i++) begin
      idx = rr_q + SWIDTH'(i);
      if (!win_val && valid_q[idx] && cnt_q[idx] == '0) begin
        win_val = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      valid_q      <= '0;
      rr_q         <= '0;
      lfsr_q       <= LFSR_SEED;
      mem_rsp_val  <= 1'b0;
      mem_rsp_ID   <= '0;
      mem_rsp_data <= '0;
      outstanding  <= '0;
      err_dup      <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        addr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
    end else begin
      lfsr_q <= {lfsr_q[14:0], fb};
      for (int s = 0; s < SLOTS; s++) begin
        if (acc && mem_req_ID == SWIDTH'(s)) begin
          valid_q[s] <= 1'b1;
          addr_q[s]  <= mem_req_addr;
          cnt_q[s]   <= lat;
        end else begin
          if (win_val && win_id == SWIDTH'(s))
            valid_q[s] <= 1'b0;
          if (valid_q[s] && cnt_q[s] != '0)
            cnt_q[s] <= cnt_q[s] - 1'b1;
        end
      end
      mem_rsp_val <= win_val;
      if (win_val) begin
        mem_rsp_ID   <= win_id;
        mem_rsp_data <= DATA_BASE + DWIDTH'(addr_q[win_id]);
        rr_q         <= win_id + 1'b1;
      end
      outstanding <= outstanding
                   + {{SWIDTH{1'b0}}, acc}
                   - {{SWIDTH{1'b0}}, win_val};
      if (mem_req_val && !acc)
        err_dup <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_ooo_responder.sv
// Bench for mem_ooo_responder: directed steps plus random traffic
// scored against a per-ID pending table.
module tb_mem_ooo_responder;

  logic        clk;
  logic        rst_;
  logic        req_val;
  logic [9:0]  req_addr;
  logic [3:0]  req_id;
  logic        cfg_fixed_lat;
  logic        mem_rsp_val;
  logic [3:0]  mem_rsp_ID;
  logic [31:0] mem_rsp_data;
  logic [4:0]  outstanding;
  logic        err_dup;

  mem_ooo_responder dut (
    .clk          (clk),
    .rst_         (rst_),
    .mem_req_val  (req_val),
    .mem_req_addr (req_addr),
    .mem_req_ID   (req_id),
    .cfg_fixed_lat(cfg_fixed_lat),
    .mem_rsp_val  (mem_rsp_val),
    .mem_rsp_ID   (mem_rsp_ID),
    .mem_rsp_data (mem_rsp_data),
    .outstanding  (outstanding),
    .err_dup      (err_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Reference: one pending entry per ID with its address and request edge
  bit         pv [16];
  logic [9:0] pa [16];
  int         pe [16];
  int         ps [16];
  int  edge_n = 0;
  int  seq_n = 0;
  int  max_rsp_seq = -1;
  bit  ooo = 0;
  bit  exp_dup = 0;
  int  hi = 3;
  int  rsp_cnt = 0;
  int  req_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) pv[i] = 0;
    exp_dup = 0;
  endtask

  task automatic tick();
    logic       rv;
    logic [9:0] ra;
    logic [3:0] ri;
    logic [3:0] id;
    int lat, cnt, mage;
    rv = req_val;
    ra = req_addr;
    ri = req_id;
    @(posedge clk);
    #1;
    edge_n++;
    if (mem_rsp_val) begin
      id = mem_rsp_ID;
      chk("rsp_pending", pv[id], 1);
      if (pv[id]) begin
        lat = edge_n - pe[id];
        chk("rsp_data", mem_rsp_data, 32'h1000_0000 + {22'b0, pa[id]});
        chk("rsp_lat_lo", lat >= 3, 1);
        chk("rsp_lat_hi", lat <= hi, 1);
        if (ps[id] < max_rsp_seq) ooo = 1;
        else max_rsp_seq = ps[id];
        pv[id] = 0;
        rsp_cnt++;
      end
    end
    if (rv) begin
      if (pv[ri]) exp_dup = 1;
      else begin
        pv[ri] = 1;
        pa[ri] = ra;
        pe[ri] = edge_n;
        ps[ri] = seq_n++;
        req_cnt++;
      end
    end
    cnt = 0;
    mage = 0;
    for (int i = 0; i < 16; i++)
      if (pv[i]) begin
        cnt++;
        if (edge_n - pe[i] > mage) mage = edge_n - pe[i];
      end
    chk("outstanding", outstanding, cnt);
    chk("err_dup", err_dup, exp_dup);
    chk("age_bound", mage < hi, 1);
    req_val = 1'b0;
  endtask

  task automatic req(input logic [3:0] id, input logic [9:0] a);
    req_val  = 1'b1;
    req_id   = id;
    req_addr = a;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_val"}, mem_rsp_val, 0);
    chk({tag, "_id"}, mem_rsp_ID, 0);
    chk({tag, "_data"}, mem_rsp_data, 0);
    chk({tag, "_outst"}, outstanding, 0);
    chk({tag, "_dup"}, err_dup, 0);
  endtask

  initial begin
    int base, issued, guard, r;
    logic [3:0] fid;
    bit found;
    rst_ = 1'b0;
    req_val = 1'b0;
    req_addr = '0;
    req_id = '0;
    cfg_fixed_lat = 1'b1;
    model_clear();
    #12;
    zero_chk("reset");
    rst_ = 1'b1;
    #1;

    // 1: single request, fixed latency
    hi = 3;
    base = rsp_cnt;
    req(4'd3, 10'h010);
    idle(6);
    chk("t1_count", rsp_cnt - base, 1);

    // 2: back-to-back IDs 0..15
    base = rsp_cnt;
    for (int i = 0; i < 16; i++) req(4'(i), 10'h3F0 + 10'(i));
    idle(6);
    chk("t2_count", rsp_cnt - base, 16);

    // 5: reuse ID 7 on its retire edge
    base = rsp_cnt;
    req(4'd7, 10'h0AB);
    idle(2);
    req(4'd7, 10'h0CD);
    idle(6);
    chk("t5_count", rsp_cnt - base, 2);

    // 3: random latency, random free IDs
    cfg_fixed_lat = 1'b0;
    hi = 25;
    base = rsp_cnt;
    max_rsp_seq = -1;
    ooo = 0;
    issued = 0;
    guard = 0;
    while (issued < 200 && guard < 3000) begin
      guard++;
      found = 0;
      fid = '0;
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++)
          if (!found && !pv[4'(r + k)]) begin
            found = 1;
            fid = 4'(r + k);
          end
      end
      if (found) begin
        req(fid, 10'($urandom));
        issued++;
      end else tick();
    end
    chk("t3_issued", issued, 200);
    idle(30);
    chk("t3_count", rsp_cnt - base, 200);
    chk("t3_ooo", ooo, 1);
    chk("t3_drained", outstanding, 0);

    // 4: duplicate ID
    cfg_fixed_lat = 1'b1;
    hi = 3;
    base = rsp_cnt;
    req(4'd5, 10'h001);
    req(4'd5, 10'h002);
    idle(6);
    chk("t4_count", rsp_cnt - base, 1);
    chk("t4_dup_sticky", err_dup, 1);

    // 6: asynchronous reset with requests in flight
    cfg_fixed_lat = 1'b0;
    hi = 25;
    req(4'd1, 10'h111);
    req(4'd2, 10'h222);
    req(4'd9, 10'h099);
    req(4'd12, 10'h3C0);
    #2;
    rst_ = 1'b0;
    #1;
    model_clear();
    zero_chk("midrst");
    #10;
    rst_ = 1'b1;
    idle(20);
    cfg_fixed_lat = 1'b1;
    hi = 3;
    base = rsp_cnt;
    req(4'd4, 10'h044);
    idle(5);
    chk("t6_count", rsp_cnt - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
